// File: rtl/seq_priority_encoder_pkg.sv
// Shared constants and FSM state type for the encoder/decoder family.
package seq_priority_encoder_pkg;
    localparam int ENC_N = 4;
    localparam int ENC_W = $clog2(ENC_N);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;
endpackage

// File: rtl/seq_priority_encoder_if.sv
// Request-vector in / index-stream out handshake bundle.
interface seq_priority_encoder_if #(parameter int N = 4);
    localparam int W = $clog2(N);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_vec;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_last;
    logic         err_zero;

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_last, err_zero
    );

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_last, err_zero
    );
endinterface

// File: rtl/seq_priority_encoder_priority_enc_n.sv
// Combinational LSB-first priority encoder: lowest set bit index plus a
// flag that exactly one bit remains.
module priority_enc_n #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] pending,
    output logic [W-1:0] idx,
    output logic         one_left
);
    always_comb begin
        idx = '0;
        // Walk downwards so the lowest set bit is the last to write idx.
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) idx = W'(i);
        end
    end

    assign one_left = (pending != '0) && ((pending & (pending - N'(1))) == '0);
endmodule

// File: rtl/seq_priority_encoder.sv
// Latches a multi-hot request vector and streams out the index of every set
// bit, lowest first, one beat per handshake.
module seq_priority_encoder
    import seq_priority_encoder_pkg::*;
#(
    parameter int N = ENC_N
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_priority_encoder_if.slave bus
);
    localparam int W = $clog2(N);

    state_t       state, state_nxt;
    logic [N-1:0] pending, pending_nxt;
    logic         err_zero, err_nxt;
    logic         init_done;
    logic [W-1:0] idx;
    logic         one_left;
    logic         accept;

    priority_enc_n #(.N(N)) u_enc (
        .pending  (pending),
        .idx      (idx),
        .one_left (one_left)
    );

    // init_done keeps in_ready low through the whole reset cycle, so every
    // output stays a function of registered state only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            err_zero  <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            err_zero  <= err_nxt;
            init_done <= 1'b1;
        end
    end

    assign accept = bus.in_valid && init_done && (state == IDLE);

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.in_vec != '0) begin
                        pending_nxt = bus.in_vec;
                        state_nxt   = SCAN;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (bus.out_ready) begin
                    // Clearing the lowest set bit is the same as clearing bit idx.
                    pending_nxt = pending & (pending - N'(1));
                    if (one_left) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.in_ready  = init_done && (state == IDLE);
    assign bus.out_valid = (state == SCAN);
    assign bus.out_idx   = idx;
    assign bus.out_last  = (state == SCAN) && one_left;
    assign bus.err_zero  = err_zero;
endmodule

// File: doc/seq_priority_encoder.md
# seq_priority_encoder

Sequential N-to-log2(N) encoder: the inverse of the team's one-hot decoder path. It accepts a multi-hot request vector over a valid/ready handshake, latches it, and emits the binary index of every set bit, one per beat, lowest index first. It serialises request masks into index streams for downstream decoders, arbiters and logic-via-decoder blocks.

## Interface
Parameters:
- N, default 4: request vector width; N >= 2.
- W, derived localparam $clog2(N): index width; 2 at default.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request vector offered.
- in_ready  out  1  block can accept a vector.
- in_vec  in  N  multi-hot request vector.
- out_valid  out  1  out_idx is valid.
- out_ready  in  1  consumer accepts the beat.
- out_idx  out  W  index of the lowest pending set bit.
- out_last  out  1  the current beat is the final one for this vector.
- err_zero  out  1  one-cycle pulse: an all-zero vector was accepted.

## Operation
- States: IDLE, SCAN. `pending` register is N bits wide.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready with in_vec!=0: pending<=in_vec, go to SCAN.
  - On in_valid&in_ready with in_vec==0: stay in IDLE, err_zero=1 for the next cycle, no output beats.
- SCAN:
  - in_ready=0; in_valid is ignored and the vector is not consumed.
  - out_valid=1.
  - out_idx = index of the lowest set bit of pending (LSB has highest priority).
  - out_last = 1 when pending has exactly one bit set.
- Beat handshake (out_valid&out_ready): clear bit out_idx in pending. If out_last, go to IDLE.
- No beat (out_ready=0): pending, out_idx and out_last hold stable.
- Number of beats per vector equals popcount(in_vec), from 1 to N.
- All outputs are decoded from registered state only. There is no combinational path from in_* or out_ready to any output.
- Reset state:
  - state=IDLE, pending=0.
  - out_valid=0, out_idx=0, out_last=0, err_zero=0.
  - in_ready=0 while rst is high, 1 from the first cycle after rst deasserts.
- Reset mid-SCAN: pending is discarded. The next cycle is IDLE with no further beats.

## Timing
- Accept at edge k -> out_valid=1 from cycle k+1 (latency 1).
- Each beat takes 1 cycle when out_ready is held high.
- The final beat handshake at edge m -> in_ready=1 in cycle m+1.
- There is one dead cycle between vectors. Peak throughput is popcount beats per popcount+1 cycles.
- err_zero is high in exactly the cycle after accepting a zero vector. in_ready stays 1 throughout.
- in_vec is sampled only on the accepting edge. Later changes have no effect.

## Structure
- Shared package: the state enum (IDLE, SCAN) and the default N/W constants. The decoder family uses the same constants.
- Sub-module: priority_enc_n (combinational, pending[N-1:0] -> idx[W-1:0], one_left). It mirrors decoder_2_4 and is reusable. The top level holds the FSM, the pending register and the handshake.

## Test plan
- Reset: hold rst 2 cycles -> out_valid=0, out_idx=0, err_zero=0, in_ready=0; in_ready=1 the cycle after release.
- in_vec=4'b1010, out_ready=1 -> beats idx=1 (last=0), then idx=3 (last=1); in_ready=1 the next cycle.
- Backpressure: in_vec=4'b1111, out_ready=0 for 3 cycles -> idx=0 held stable; then out_ready=1 -> 0, 1, 2, 3 with last only on 3.
- in_vec=4'b0000 -> err_zero is a single 1-cycle pulse, out_valid stays 0, in_ready stays 1.
- Vector 4'b1100 in SCAN while in_valid=1 with 4'b0001 -> not accepted until IDLE; then a single beat idx=0, last=1.
- in_vec=4'b0110, assert rst after the first beat (idx=1) -> next cycle IDLE, out_valid=0, no idx=2 beat ever.
